// File: rtl/csa_16bit.sv
// 16-bit carry-select adder with registered {cout,sum}; segments of BLOCK_W bits.
// Optional CSA_OVF_EN adds a registered signed-overflow output ovf.
module csa_16bit #(
  parameter int unsigned BLOCK_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
`ifdef CSA_OVF_EN
  ,
  output logic        ovf
`endif
);

  localparam int unsigned NSEG = 16 / BLOCK_W;

  logic [15:0]   s_comb;
  logic [NSEG:0] seg_carry;

  assign seg_carry[0] = cin;

  genvar k, b;
  generate
    for (k = 0; k < NSEG; k++) begin : g_seg
      if (k == 0) begin : g_first
        logic [BLOCK_W:0] c;
        assign c[0] = seg_carry[0];
        for (b = 0; b < BLOCK_W; b++) begin : g_bit
          assign s_comb[b] = x[b] ^ y[b] ^ c[b];
          assign c[b+1]    = (x[b] & y[b]) | (c[b] & (x[b] ^ y[b]));
        end
        assign seg_carry[1] = c[BLOCK_W];
      end else begin : g_upper
        // Both carry-in assumptions are computed up front; the incoming carry only drives the mux.
        logic [BLOCK_W:0]   c0, c1;
        logic [BLOCK_W-1:0] s0, s1;
        assign c0[0] = 1'b0;
        assign c1[0] = 1'b1;
        for (b = 0; b < BLOCK_W; b++) begin : g_bit
          assign s0[b]    = x[k*BLOCK_W+b] ^ y[k*BLOCK_W+b] ^ c0[b];
          assign c0[b+1]  = (x[k*BLOCK_W+b] & y[k*BLOCK_W+b]) |
                            (c0[b] & (x[k*BLOCK_W+b] ^ y[k*BLOCK_W+b]));
          assign s1[b]    = x[k*BLOCK_W+b] ^ y[k*BLOCK_W+b] ^ c1[b];
          assign c1[b+1]  = (x[k*BLOCK_W+b] & y[k*BLOCK_W+b]) |
                            (c1[b] & (x[k*BLOCK_W+b] ^ y[k*BLOCK_W+b]));
        end
        assign s_comb[k*BLOCK_W +: BLOCK_W] = seg_carry[k] ? s1 : s0;
        assign seg_carry[k+1]               = seg_carry[k] ? c1[BLOCK_W] : c0[BLOCK_W];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      sum  <= '0;
      cout <= 1'b0;
    end else begin
      sum  <= s_comb;
      cout <= seg_carry[NSEG];
    end
  end

`ifdef CSA_OVF_EN
  always_ff @(posedge clk) begin
    if (rst) ovf <= 1'b0;
    else     ovf <= (x[15] == y[15]) && (s_comb[15] != x[15]);
  end
`endif

endmodule

// File: tb/tb_csa_16bit.sv
// Directed and random checks of csa_16bit for every legal BLOCK_W in parallel.
module tb_csa_16bit;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] x, y;
  logic        cin;
  logic [15:0] sum_a [5];
  logic        cout_a[5];
  logic        ovf_a [5];
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  generate
    for (genvar i = 0; i < 5; i++) begin : g_dut
      csa_16bit #(.BLOCK_W(1 << i)) u_dut (
        .clk (clk),
        .rst (rst),
        .x   (x),
        .y   (y),
        .cin (cin),
        .sum (sum_a[i]),
`ifdef CSA_OVF_EN
        .cout(cout_a[i]),
        .ovf (ovf_a[i])
`else
        .cout(cout_a[i])
`endif
      );
`ifndef CSA_OVF_EN
      assign ovf_a[i] = 1'b0;
`endif
    end
  endgenerate

  task automatic drive(input logic r, input logic [15:0] a, input logic [15:0] b, input logic c);
    @(negedge clk);
    rst = r; x = a; y = b; cin = c;
  endtask

  task automatic test_reset();
    drive(1'b1, 16'hFFFF, 16'h0001, 1'b1);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (sum_a[i] !== 16'h0000 || cout_a[i] !== 1'b0 || ovf_a[i] !== 1'b0) begin
        bad++;
        $display("FAIL reset bw_idx=%0d got sum=%h cout=%b ovf=%b want 0000 0 0",
                 i, sum_a[i], cout_a[i], ovf_a[i]);
      end
    end
  endtask

  task automatic test_vector(input string name, input logic [15:0] a, input logic [15:0] b,
                             input logic c, input logic [15:0] es, input logic ec, input logic eo);
    drive(1'b0, a, b, c);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (sum_a[i] !== es || cout_a[i] !== ec) begin
        bad++;
        $display("FAIL %s bw_idx=%0d got sum=%h cout=%b want sum=%h cout=%b",
                 name, i, sum_a[i], cout_a[i], es, ec);
      end
`ifdef CSA_OVF_EN
      total++;
      if (ovf_a[i] !== eo) begin
        bad++;
        $display("FAIL %s_ovf bw_idx=%0d got %b want %b", name, i, ovf_a[i], eo);
      end
`endif
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] vx[4] = '{16'h61AC, 16'hFF00, 16'hAAAA, 16'hFFFF};
    logic [15:0] vy[4] = '{16'h003C, 16'h0AD5, 16'h5555, 16'hFFFF};
    logic        vc[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [15:0] es[4] = '{16'h61E8, 16'h09D5, 16'h0000, 16'hFFFF};
    logic        ec[4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    for (int v = 0; v < 4; v++) begin
      drive(1'b0, vx[v], vy[v], vc[v]);
      // Just before the capturing edge the previous result must still be held.
      if (v > 0) begin
        total++;
        if (sum_a[2] !== es[v-1] || cout_a[2] !== ec[v-1]) begin
          bad++;
          $display("FAIL b2b_hold v=%0d got %b_%h want %b_%h", v, cout_a[2], sum_a[2], ec[v-1], es[v-1]);
        end
      end
      @(posedge clk); #1;
      for (int i = 0; i < 5; i++) begin
        total++;
        if (sum_a[i] !== es[v] || cout_a[i] !== ec[v]) begin
          bad++;
          $display("FAIL b2b v=%0d bw_idx=%0d got %b_%h want %b_%h",
                   v, i, cout_a[i], sum_a[i], ec[v], es[v]);
        end
      end
    end
  endtask

  task automatic test_reset_midstream();
    drive(1'b0, 16'h1234, 16'h4321, 1'b1);
    drive(1'b1, 16'hFFFF, 16'hFFFF, 1'b1);
    @(posedge clk); #1;
    total++;
    if (sum_a[2] !== 16'h0000 || cout_a[2] !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset got %b_%h want 0_0000", cout_a[2], sum_a[2]);
    end
    test_vector("post_reset", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    logic [16:0] e;
    logic        r;
    logic [15:0] a, b;
    logic        c;
    for (int n = 0; n < 2000; n++) begin
      r = ($urandom_range(0, 19) == 0);
      a = 16'($urandom);
      b = 16'($urandom);
      c = 1'($urandom);
      drive(r, a, b, c);
      e = r ? 17'h0 : ({1'b0, a} + {1'b0, b} + {16'h0, c});
      @(posedge clk); #1;
      for (int i = 0; i < 5; i++) begin
        total++;
        if ({cout_a[i], sum_a[i]} !== e) begin
          bad++;
          $display("FAIL random n=%0d bw_idx=%0d x=%h y=%h cin=%b rst=%b got %h want %h",
                   n, i, a, b, c, r, {cout_a[i], sum_a[i]}, e);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; x = '0; y = '0; cin = 1'b0;
    test_reset();
    test_vector("no_carry",   16'h61AC, 16'h003C, 1'b0, 16'h61E8, 1'b0, 1'b0);
    test_vector("carry_out",  16'hFF00, 16'h0AD5, 1'b0, 16'h09D5, 1'b1, 1'b0);
    test_vector("full_chain", 16'hAAAA, 16'h5555, 1'b1, 16'h0000, 1'b1, 1'b0);
    test_vector("max",        16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    test_vector("signed_ovf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    test_vector("neg_ovf",    16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
    test_back_to_back();
    test_reset_midstream();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
